// File: rtl/freq_meter.sv
// freq_meter
// Gated frequency meter. Counts rising edges of the asynchronous input `in`
// over a window of GATE clk cycles, then publishes the count for one window
// period with a one-cycle valid strobe and a saturation flag. Windows run
// back-to-back with no dead cycle and no handshake.
//
// Parameters
//   GATE   window length in clk cycles (>= 2)
//   CNT_W  width of the edge counter and of freq
// Ports
//   clk    system clock, all flops on its rising edge
//   rst    synchronous active-high reset; discards the partial window
//   in     signal to measure (asynchronous)
//   freq   rising-edge count of the last completed window (saturated)
//   valid  one-cycle pulse: freq/ovf were updated this cycle
//   ovf    the last completed window saturated the edge counter
module freq_meter #(
  parameter int GATE  = 1000,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  output logic [CNT_W-1:0] freq,
  output logic             valid,
  output logic             ovf
);

  localparam int GW = (GATE > 1) ? $clog2(GATE) : 1;
  localparam logic [GW-1:0]    LAST = GW'(GATE - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic             s1_reg, s2_reg, s3_reg;
  logic             rise;
  logic [GW-1:0]    gcnt_reg;
  logic [CNT_W-1:0] ecnt_reg;
  logic             sat_reg;

  logic             last;
  logic             inc_ovf;
  logic [CNT_W-1:0] ecnt_next;

  // Synchronizer and edge detector. While reset is held, s2 and s3 both
  // follow s1: rise stays low and the chain settles to the present level of
  // `in`, so a level held across reset is never mistaken for an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg <= in;
      s2_reg <= s1_reg;
      s3_reg <= s1_reg;
    end else begin
      s1_reg <= in;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  assign rise = s2_reg & ~s3_reg;

  // Saturating increment shared by the running count and the published
  // result, so an edge on the last cycle belongs to the closing window.
  assign last      = (gcnt_reg == LAST);
  assign inc_ovf   = rise & (ecnt_reg == CMAX);
  assign ecnt_next = inc_ovf ? CMAX : (ecnt_reg + CNT_W'(rise));

  always_ff @(posedge clk) begin
    if (rst) begin
      gcnt_reg <= '0;
      ecnt_reg <= '0;
      sat_reg  <= 1'b0;
      freq     <= '0;
      ovf      <= 1'b0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (last) begin
        gcnt_reg <= '0;
        freq     <= ecnt_next;
        ovf      <= sat_reg | inc_ovf;
        valid    <= 1'b1;
        // Nothing carries into the next window.
        ecnt_reg <= '0;
        sat_reg  <= 1'b0;
      end else begin
        gcnt_reg <= gcnt_reg + GW'(1);
        ecnt_reg <= ecnt_next;
        if (inc_ovf) begin
          sat_reg <= 1'b1;
        end
      end
    end
  end

endmodule
